// File: rtl/intercal_pkg.sv
// -----------------------------------------------------------------------------
// intercal_pkg
// Shared types and constants for the INTERCAL postfix expression sequencer.
//   tok_kind_t : token kinds carried on tok_kind
//   OP_*       : opcode map of the downstream INTERCAL ALU
//   state_t    : sequencer FSM states
//   is_unary_op / is_binary_op : opcode class helpers
// -----------------------------------------------------------------------------
package intercal_pkg;

    typedef enum logic [1:0] {
        TOK_PUSH   = 2'd0,
        TOK_UNARY  = 2'd1,
        TOK_BINARY = 2'd2,
        TOK_END    = 2'd3
    } tok_kind_t;

    localparam logic [3:0] OP_PASS_A    = 4'd0;
    localparam logic [3:0] OP_PASS_B    = 4'd1;
    localparam logic [3:0] OP_UNAND16   = 4'd2;
    localparam logic [3:0] OP_UNAND32   = 4'd3;
    localparam logic [3:0] OP_UNOR16    = 4'd4;
    localparam logic [3:0] OP_UNOR32    = 4'd5;
    localparam logic [3:0] OP_UNXOR16   = 4'd6;
    localparam logic [3:0] OP_UNXOR32   = 4'd7;
    localparam logic [3:0] OP_MINGLE_LO = 4'd8;
    localparam logic [3:0] OP_MINGLE_HI = 4'd9;
    localparam logic [3:0] OP_SELECT16  = 4'd10;
    localparam logic [3:0] OP_SELECT32  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic logic is_unary_op(input logic [3:0] op);
        return op inside {OP_UNAND16, OP_UNAND32, OP_UNOR16,
                          OP_UNOR32, OP_UNXOR16, OP_UNXOR32};
    endfunction

    function automatic logic is_binary_op(input logic [3:0] op);
        return op inside {OP_MINGLE_LO, OP_MINGLE_HI, OP_SELECT16, OP_SELECT32};
    endfunction

    // Pass-through codes are legal for the ALU but not meaningful as
    // expression operators; kept here so the full map lives in one place.
    function automatic logic is_pass_op(input logic [3:0] op);
        return op inside {OP_PASS_A, OP_PASS_B};
    endfunction

endpackage

// File: rtl/intercal_opstack.sv
// -----------------------------------------------------------------------------
// intercal_opstack
// DEPTH x 32 operand stack for the expression sequencer.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (clears sp)
//   clear               : empty the stack (sp := 0), wins over other requests
//   push, push_data     : write push_data at stack[sp], sp+1 (ignored when full)
//   pop2_replace        : stack[sp-2] := wr_data, sp-1 (ignored if sp<2)
//   replace_top         : stack[sp-1] := wr_data (ignored if empty)
//   wr_data             : ALU result for the two replace requests
//   sp, top, next       : stack pointer, stack[sp-1], stack[sp-2]
//   can_push/can_unary/can_binary : overflow / underflow qualification
// -----------------------------------------------------------------------------
module intercal_opstack
    import intercal_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           push,
    input  logic [31:0]    push_data,
    input  logic           pop2_replace,
    input  logic           replace_top,
    input  logic [31:0]    wr_data,
    output logic [SPW-1:0] sp,
    output logic [31:0]    top,
    output logic [31:0]    next,
    output logic           can_push,
    output logic           can_unary,
    output logic           can_binary
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     mem [DEPTH];
    logic [IDXW-1:0] push_idx;
    logic [IDXW-1:0] top_idx;
    logic [IDXW-1:0] next_idx;
    logic            do_push;
    logic            do_pop2;
    logic            do_rep;

    assign can_push   = (sp < SPW'(DEPTH));
    assign can_unary  = (sp != '0);
    assign can_binary = (sp >= SPW'(2));

    assign do_push = push         && can_push;
    assign do_pop2 = pop2_replace && can_binary;
    assign do_rep  = replace_top  && can_unary;

    // Index arithmetic wraps when sp is too small; the can_* gates make
    // sure a wrapped index is never used for a write or a meaningful read.
    assign push_idx = IDXW'(sp);
    assign top_idx  = IDXW'(sp - SPW'(1));
    assign next_idx = IDXW'(sp - SPW'(2));

    assign top  = mem[top_idx];
    assign next = mem[next_idx];

    // Storage: data only, no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[push_idx] <= push_data;
        end else if (do_pop2) begin
            mem[next_idx] <= wr_data;
        end else if (do_rep) begin
            mem[top_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SPW'(1);
        end else if (do_pop2) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/intercal_expr_eval.sv
// -----------------------------------------------------------------------------
// intercal_expr_eval
// Postfix expression sequencer sitting in front of the combinational INTERCAL
// ALU. Tokens (PUSH/UNARY/BINARY/END) build and reduce an operand stack; each
// UNARY/BINARY token issues one ALU operation whose result is written back one
// cycle later. END returns the single remaining value or an error flag.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   tok_valid/tok_ready                : token handshake (ready only in IDLE)
//   tok_kind, tok_op, tok_data         : token kind, ALU opcode, constant
//   alu_s, alu_a, alu_b                : registered ALU opcode and operands
//   alu_f                              : ALU result (combinational from s/a/b)
//   res_valid/res_ready                : result handshake
//   res_data, res_err                  : final value (0 on error), error flag
// Build option:
//   INTERCAL_EXPR_OPCHECK_EN : when defined, UNARY must carry opcode 2..7 and
//   BINARY opcode 8..11; any other opcode faults the expression.
// -----------------------------------------------------------------------------
module intercal_expr_eval
    import intercal_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic [1:0]  tok_kind,
    input  logic [3:0]  tok_op,
    input  logic [31:0] tok_data,
    output logic [3:0]  alu_s,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_f,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err
);

    state_t          state;
    tok_kind_t       kind;
    logic            err;
    logic            is_bin;
    logic            tok_accept;
    logic            live;
    logic            do_push;
    logic            issue_unary;
    logic            issue_binary;
    logic            stk_clear;
    logic            end_ok;
    logic            unary_op_ok;
    logic            binary_op_ok;
    logic [SPW-1:0]  sp;
    logic [31:0]     top;
    logic [31:0]     next;
    logic            can_push;
    logic            can_unary;
    logic            can_binary;

    assign kind = tok_kind_t'(tok_kind);

`ifdef INTERCAL_EXPR_OPCHECK_EN
    assign unary_op_ok  = is_unary_op(tok_op);
    assign binary_op_ok = is_binary_op(tok_op);
`else
    assign unary_op_ok  = 1'b1;
    assign binary_op_ok = 1'b1;
`endif

    // Gating with rst_n keeps ready low for the whole reset cycle even if the
    // FSM was already sitting in IDLE.
    assign tok_ready  = rst_n && (state == ST_IDLE);
    assign res_valid  = (state == ST_OUT);
    assign tok_accept = tok_valid && tok_ready;
    // Once faulted, operand tokens are swallowed without touching the stack.
    assign live       = tok_accept && !err;

    assign do_push      = live && (kind == TOK_PUSH)   && can_push;
    assign issue_unary  = live && (kind == TOK_UNARY)  && can_unary  && unary_op_ok;
    assign issue_binary = live && (kind == TOK_BINARY) && can_binary && binary_op_ok;
    assign stk_clear    = tok_accept && (kind == TOK_END);
    assign end_ok       = !err && (sp == SPW'(1));

    intercal_opstack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (stk_clear),
        .push         (do_push),
        .push_data    (tok_data),
        .pop2_replace ((state == ST_EXEC) && is_bin),
        .replace_top  ((state == ST_EXEC) && !is_bin),
        .wr_data      (alu_f),
        .sp           (sp),
        .top          (top),
        .next         (next),
        .can_push     (can_push),
        .can_unary    (can_unary),
        .can_binary   (can_binary)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            err      <= 1'b0;
            is_bin   <= 1'b0;
            alu_s    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                // Issue stage: operands and opcode registered toward the ALU.
                ST_IDLE: begin
                    if (tok_accept) begin
                        if (kind == TOK_END) begin
                            state    <= ST_OUT;
                            err      <= 1'b0;
                            res_data <= end_ok ? top : '0;
                            res_err  <= !end_ok;
                        end else if (!err) begin
                            if (issue_unary) begin
                                alu_s  <= tok_op;
                                alu_a  <= top;
                                alu_b  <= '0;
                                is_bin <= 1'b0;
                                state  <= ST_EXEC;
                            end else if (issue_binary) begin
                                alu_s  <= tok_op;
                                alu_a  <= next;
                                alu_b  <= top;
                                is_bin <= 1'b1;
                                state  <= ST_EXEC;
                            end else if (!do_push) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                // Writeback stage: alu_f lands in the stack this cycle.
                ST_EXEC: state <= ST_IDLE;
                ST_OUT: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intercal_expr_eval.sv
module tb_intercal_expr_eval;
    import intercal_pkg::*;

    localparam int DEPTH = 8;
    localparam int NV    = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tok_valid;
    logic        tok_ready;
    logic [1:0]  tok_kind;
    logic [3:0]  tok_op;
    logic [31:0] tok_data;
    logic [3:0]  alu_s;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_f;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    intercal_expr_eval #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_kind  (tok_kind),
        .tok_op    (tok_op),
        .tok_data  (tok_data),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    // Reference INTERCAL ALU.
    function automatic logic [15:0] sel16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        int j;
        r = '0;
        j = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                r[j] = a[i];
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] s, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic [15:0] l;
        logic [15:0] rl;
        logic [31:0] ra;
        int j;
        r  = '0;
        l  = a[15:0];
        rl = {l[0], l[15:1]};
        ra = {a[0], a[31:1]};
        case (s)
            4'd0:  r = a;
            4'd1:  r = b;
            4'd2:  r = {16'h0, l & rl};
            4'd3:  r = a & ra;
            4'd4:  r = {16'h0, l | rl};
            4'd5:  r = a | ra;
            4'd6:  r = {16'h0, l ^ rl};
            4'd7:  r = a ^ ra;
            4'd8:  for (int i = 0; i < 16; i++) begin r[2*i+1] = a[i];    r[2*i] = b[i];    end
            4'd9:  for (int i = 0; i < 16; i++) begin r[2*i+1] = a[16+i]; r[2*i] = b[16+i]; end
            4'd10: r = {sel16(a[31:16], b[31:16]), sel16(a[15:0], b[15:0])};
            4'd11: begin
                j = 0;
                for (int i = 0; i < 32; i++) begin
                    if (b[i]) begin
                        r[j] = a[i];
                        j++;
                    end
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb alu_f = alu_model(alu_s, alu_a, alu_b);

    typedef struct {
        int               n;
        logic [5:0][1:0]  kind;
        logic [5:0][3:0]  op;
        logic [5:0][31:0] data;
        logic [31:0]      exp_data;
        logic             exp_err;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [3:0] op, input logic [31:0] d);
        bit done;
        done      = 1'b0;
        tok_valid = 1'b1;
        tok_kind  = k;
        tok_op    = op;
        tok_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (tok_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        tok_valid = 1'b0;
        last_acc  = cyc;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL tok_accept: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic get_result(input string name, input logic [31:0] exp_d, input logic exp_e);
        bit done;
        done      = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (res_valid) begin
                chk({name, "_data"}, res_data, exp_d);
                chk({name, "_err"}, 32'(res_err), 32'(exp_e));
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        res_ready = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_valid: got no res_valid expected res_valid within 20 cycles", name);
        end
    endtask

    task automatic stall_check(input string name, input logic [31:0] exp_d, input logic exp_e);
        bit seen;
        seen      = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_valid: got no res_valid expected res_valid", name);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(res_valid), 32'd1);
            chk({name, "_hold_data"}, res_data, exp_d);
            chk({name, "_hold_err"}, 32'(res_err), 32'(exp_e));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({name, "_released"}, 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_tok(input int v, input int t, input logic [1:0] k,
                           input logic [3:0] op, input logic [31:0] d);
        vecs[v].kind[t] = k;
        vecs[v].op[t]   = op;
        vecs[v].data[t] = d;
        vecs[v].n       = t + 1;
    endtask

    task automatic set_exp(input int v, input logic [31:0] d, input logic e);
        vecs[v].exp_data = d;
        vecs[v].exp_err  = e;
    endtask

    initial begin
        int acc_bin;

        // Vector table: tokens plus hand-computed result.
        set_tok(0, 0, TOK_PUSH, 0, 32'h0000FFFF);
        set_tok(0, 1, TOK_PUSH, 0, 32'h00000000);
        set_tok(0, 2, TOK_BINARY, 8, 0);
        set_tok(0, 3, TOK_END, 0, 0);
        set_exp(0, 32'hAAAAAAAA, 1'b0);

        set_tok(1, 0, TOK_PUSH, 0, 32'hAAAAAAAA);
        set_tok(1, 1, TOK_PUSH, 0, 32'hAAAAAAAA);
        set_tok(1, 2, TOK_BINARY, 11, 0);
        set_tok(1, 3, TOK_END, 0, 0);
        set_exp(1, 32'h0000FFFF, 1'b0);

        // Follows a binary op that left alu_b=0xAAAAAAAA, so a stale alu_b
        // would corrupt the high-half mingle.
        set_tok(2, 0, TOK_PUSH, 0, 32'hFFFF0000);
        set_tok(2, 1, TOK_UNARY, 9, 0);
        set_tok(2, 2, TOK_END, 0, 0);
`ifdef INTERCAL_EXPR_OPCHECK_EN
        set_exp(2, 32'h00000000, 1'b1);
`else
        set_exp(2, 32'hAAAAAAAA, 1'b0);
`endif

        set_tok(3, 0, TOK_PUSH, 0, 32'h00000001);
        set_tok(3, 1, TOK_UNARY, 7, 0);
        set_tok(3, 2, TOK_END, 0, 0);
        set_exp(3, 32'h80000001, 1'b0);

        set_tok(4, 0, TOK_PUSH, 0, 32'h00000003);
        set_tok(4, 1, TOK_BINARY, 8, 0);
        set_tok(4, 2, TOK_PUSH, 0, 32'h00000004);
        set_tok(4, 3, TOK_END, 0, 0);
        set_exp(4, 32'h00000000, 1'b1);

        set_tok(5, 0, TOK_PUSH, 0, 32'h00000005);
        set_tok(5, 1, TOK_END, 0, 0);
        set_exp(5, 32'h00000005, 1'b0);

        set_tok(6, 0, TOK_PUSH, 0, 32'h00000001);
        set_tok(6, 1, TOK_PUSH, 0, 32'h00000002);
        set_tok(6, 2, TOK_END, 0, 0);
        set_exp(6, 32'h00000000, 1'b1);

        set_tok(7, 0, TOK_END, 0, 0);
        set_exp(7, 32'h00000000, 1'b1);

        set_tok(8, 0, TOK_PUSH, 0, 32'h12345678);
        set_tok(8, 1, TOK_PUSH, 0, 32'h9ABCDEF0);
        set_tok(8, 2, TOK_BINARY, 1, 0);
        set_tok(8, 3, TOK_END, 0, 0);
`ifdef INTERCAL_EXPR_OPCHECK_EN
        set_exp(8, 32'h00000000, 1'b1);
`else
        set_exp(8, 32'h9ABCDEF0, 1'b0);
`endif

        // mingle lo -> 0xAAAAAAAA, then unxor32 -> 0xAAAAAAAA ^ 0x55555555
        set_tok(9, 0, TOK_PUSH, 0, 32'h0000FFFF);
        set_tok(9, 1, TOK_PUSH, 0, 32'h00000000);
        set_tok(9, 2, TOK_BINARY, 8, 0);
        set_tok(9, 3, TOK_UNARY, 7, 0);
        set_tok(9, 4, TOK_END, 0, 0);
        set_exp(9, 32'hFFFFFFFF, 1'b0);

        set_tok(10, 0, TOK_UNARY, 7, 0);
        set_tok(10, 1, TOK_PUSH, 0, 32'h00000001);
        set_tok(10, 2, TOK_END, 0, 0);
        set_exp(10, 32'h00000000, 1'b1);

        // Reset
        rst_n     = 1'b0;
        tok_valid = 1'b0;
        tok_kind  = '0;
        tok_op    = '0;
        tok_data  = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_tok_ready_low", 32'(tok_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tok_ready", 32'(tok_ready), 32'd1);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_res_err", 32'(res_err), 32'd0);
        chk("reset_res_data", res_data, 32'd0);
        chk("reset_alu_s", 32'(alu_s), 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_b", alu_b, 32'd0);
        @(posedge clk);
        #1;

        // Table-driven expressions
        for (int v = 0; v < NV; v++) begin
            for (int t = 0; t < vecs[v].n; t++) begin
                send(vecs[v].kind[t], vecs[v].op[t], vecs[v].data[t]);
            end
            get_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_err);
        end

        // EXEC visibility and op-to-next-token spacing
        send(TOK_PUSH, 0, 32'h0000FFFF);
        send(TOK_PUSH, 0, 32'h00000000);
        send(TOK_BINARY, 8, 0);
        acc_bin = last_acc;
        chk("exec_tok_ready", 32'(tok_ready), 32'd0);
        chk("exec_alu_s", 32'(alu_s), 32'd8);
        chk("exec_alu_a", alu_a, 32'h0000FFFF);
        chk("exec_alu_b", alu_b, 32'h00000000);
        send(TOK_END, 0, 0);
        chk("op_to_next_gap", 32'(last_acc - acc_bin), 32'd2);
        get_result("exec_seq", 32'hAAAAAAAA, 1'b0);

        // Unary spacing: PUSH then UNARY back to back, END two cycles later
        send(TOK_PUSH, 0, 32'h00000001);
        acc_bin = last_acc;
        send(TOK_UNARY, 7, 0);
        chk("push_to_unary_gap", 32'(last_acc - acc_bin), 32'd1);
        chk("unary_exec_tok_ready", 32'(tok_ready), 32'd0);
        chk("unary_exec_alu_b", alu_b, 32'd0);
        acc_bin = last_acc;
        send(TOK_END, 0, 0);
        chk("unary_to_end_gap", 32'(last_acc - acc_bin), 32'd2);
        get_result("unary_seq", 32'h80000001, 1'b0);

        // Overflow: DEPTH+1 pushes
        for (int i = 0; i <= DEPTH; i++) send(TOK_PUSH, 0, 32'(i + 1));
        send(TOK_END, 0, 0);
        get_result("overflow", 32'h0, 1'b1);

        // Stalled result handshake, error and good result
        send(TOK_PUSH, 0, 32'h00000001);
        send(TOK_PUSH, 0, 32'h00000002);
        send(TOK_END, 0, 0);
        stall_check("stall_err", 32'h0, 1'b1);
        send(TOK_PUSH, 0, 32'h5A5A1234);
        send(TOK_END, 0, 0);
        stall_check("stall_ok", 32'h5A5A1234, 1'b0);

        // Reset in the middle of EXEC discards the expression
        send(TOK_PUSH, 0, 32'h00000001);
        send(TOK_PUSH, 0, 32'h00000002);
        send(TOK_BINARY, 8, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midexec_rst_tok_ready", 32'(tok_ready), 32'd1);
        chk("midexec_rst_res_valid", 32'(res_valid), 32'd0);
        chk("midexec_rst_alu_s", 32'(alu_s), 32'd0);
        @(posedge clk);
        #1;
        send(TOK_PUSH, 0, 32'h00000009);
        send(TOK_END, 0, 0);
        get_result("after_rst", 32'h00000009, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
